// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state encoding and constants for the UART receiver control stage
package uart_rx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;
  localparam logic [4:0] PRESC_8 = 5'd8;
  localparam logic [4:0] PRESC_16 = 5'd16;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, frame config, sampler handshake and received-word outputs
interface uart_rx_if #(parameter int DATA_WIDTH = 8);
  logic                  RX_IN;
  logic [4:0]            Prescale;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  sampled_bit;
  logic                  data_samp_en;
  logic [4:0]            edge_cnt;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  modport master (output RX_IN, Prescale, PAR_EN, PAR_TYP, sampled_bit,
                  input data_samp_en, edge_cnt, P_DATA, data_valid, par_err, stp_err);
  modport slave (input RX_IN, Prescale, PAR_EN, PAR_TYP, sampled_bit,
                 output data_samp_en, edge_cnt, P_DATA, data_valid, par_err, stp_err);
endinterface

// File: rtl/uart_rx_edge_bit_counter.sv
// edge_bit_counter: oversampling edge index within a bit and data-bit index within a frame
module edge_bit_counter #(parameter int BW = 3) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic          bit_en_i,
  input  logic          bit_clr_i,
  input  logic [4:0]    last_i,
  output logic [4:0]    edge_cnt_o,
  output logic [BW-1:0] bit_cnt_o,
  output logic          wrap_o
);
  logic [4:0] edge_q, edge_d;
  logic [BW-1:0] bit_q, bit_d;
  always_comb begin
    wrap_o = edge_q == last_i;
    edge_d = clr_i ? '0 : en_i ? (wrap_o ? '0 : edge_q + 5'd1) : edge_q;
    bit_d = bit_clr_i ? '0 : (bit_en_i && wrap_o) ? bit_q + 1'b1 : bit_q;
  end
  always_ff @(posedge CLK) begin
    if (!RST) begin
      edge_q <= '0;
      bit_q <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q <= bit_d;
    end
  end
  assign edge_cnt_o = edge_q;
  assign bit_cnt_o = bit_q;
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: start detection, sampler timing, LSB-first deserializer and parity/stop checks
module uart_rx_ctrl import uart_rx_pkg::*; #(parameter int DATA_WIDTH = 8) (
  input logic     CLK,
  input logic     RST,
  uart_rx_if.slave bus
);
  localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  state_e state_q, state_d;
  logic p16_q, p16_d, pen_q, pen_d, ptyp_q, ptyp_d;
  logic dv_q, dv_d, perr_q, perr_d, serr_q, serr_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, data_q, data_d;
  logic [4:0] edge_cnt, last, sp;
  logic [BW-1:0] bit_cnt;
  logic wrap, at_sp;
  assign last = p16_q ? 5'd15 : 5'd7;
  assign sp = p16_q ? 5'd10 : 5'd6;
  assign at_sp = edge_cnt == sp;
  edge_bit_counter #(.BW(BW)) u_cnt (
    .CLK(CLK), .RST(RST),
    .en_i(state_q != IDLE),
    .clr_i(state_q == IDLE || state_d == IDLE),
    .bit_en_i(state_q == DATA),
    .bit_clr_i(state_q != DATA),
    .last_i(last),
    .edge_cnt_o(edge_cnt),
    .bit_cnt_o(bit_cnt),
    .wrap_o(wrap)
  );
  always_comb begin
    state_d = state_q;
    p16_d = p16_q;
    pen_d = pen_q;
    ptyp_d = ptyp_q;
    perr_d = perr_q;
    serr_d = serr_q;
    shift_d = shift_q;
    data_d = data_q;
    dv_d = 1'b0;
    case (state_q)
      IDLE: if (!bus.RX_IN) begin
        state_d = START;
        p16_d = bus.Prescale != PRESC_8;
        pen_d = bus.PAR_EN;
        ptyp_d = bus.PAR_TYP;
        perr_d = 1'b0;
        serr_d = 1'b0;
      end
      START: state_d = (at_sp && bus.sampled_bit) ? IDLE : wrap ? DATA : START;
      DATA: begin
        if (at_sp) shift_d = {bus.sampled_bit, shift_q[DATA_WIDTH-1:1]};
        if (wrap && bit_cnt == BW'(DATA_WIDTH - 1)) state_d = pen_q ? PARITY : STOP;
      end
      PARITY: begin
        if (at_sp) perr_d = bus.sampled_bit != (ptyp_q == PAR_ODD ? ~^shift_q : ^shift_q);
        if (wrap) state_d = STOP;
      end
      STOP: if (at_sp) begin
        // leave half a bit early so a back-to-back start bit is not missed
        serr_d = ~bus.sampled_bit;
        data_d = (!perr_q && bus.sampled_bit) ? shift_q : data_q;
        dv_d = !perr_q && bus.sampled_bit;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      {p16_q, pen_q, ptyp_q, dv_q, perr_q, serr_q} <= '0;
      shift_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      p16_q <= p16_d;
      pen_q <= pen_d;
      ptyp_q <= ptyp_d;
      dv_q <= dv_d;
      perr_q <= perr_d;
      serr_q <= serr_d;
      shift_q <= shift_d;
      data_q <= data_d;
    end
  end
  assign bus.data_samp_en = state_q != IDLE;
  assign bus.edge_cnt = edge_cnt;
  assign bus.P_DATA = data_q;
  assign bus.data_valid = dv_q;
  assign bus.par_err = perr_q;
  assign bus.stp_err = serr_q;
endmodule
